// File: rtl/bip_control_unit.sv
// Control unit for a 16-bit accumulator-based BIP processor.
// Sequences FETCH/DECODE/EXEC for each instruction, owns the program
// counter, instruction register and retired-instruction counter, and
// emits the memory strobes and datapath selects.
module bip_control_unit #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_OPCODE      = 5,
  parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
  parameter int NB_SELECTOR_A  = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_INSTRUCTION-1:0] i_instruction,
  output logic [NB_ADDR-1:0]        o_pc_addr,
  output logic                      o_rd_prog,
  output logic [NB_ADDR-1:0]        o_data_addr,
  output logic                      o_rd_data,
  output logic                      o_wr_data,
  output logic [NB_OPERAND-1:0]     o_operand,
  output logic [NB_SELECTOR_A-1:0]  o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_enb_acc,
  output logic                      o_operation,
  output logic                      o_busy,
  output logic                      o_halted,
  output logic [15:0]               o_instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  state_t                      state;
  state_t                      next_state;
  logic [NB_ADDR-1:0]          pc;
  logic [NB_INSTRUCTION-1:0]   ir;
  logic [15:0]                 count;
  logic [NB_OPCODE-1:0]        dec_opcode;
  logic [NB_OPCODE-1:0]        ex_opcode;

  // DECODE looks at the live memory word; EXEC works from the latched IR.
  assign dec_opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign ex_opcode  = ir[NB_INSTRUCTION-1 -: NB_OPCODE];

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Program counter, instruction register and retired-instruction counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc    <= '0;
      ir    <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (i_start) begin
            pc    <= '0;
            count <= '0;
          end
        end
        DECODE: ir <= i_instruction;
        EXEC: begin
          pc <= pc + 1'b1;
          if (count != 16'hFFFF) count <= count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; everything is forced low while reset is held
  // so an instruction caught by reset cannot emit a strobe in that cycle.
  always_comb begin
    next_state    = state;
    o_pc_addr     = '0;
    o_rd_prog     = 1'b0;
    o_data_addr   = '0;
    o_rd_data     = 1'b0;
    o_wr_data     = 1'b0;
    o_operand     = '0;
    o_sel_a       = 2'b00;
    o_sel_b       = 1'b0;
    o_enb_acc     = 1'b0;
    o_operation   = 1'b0;
    o_busy        = 1'b0;
    o_halted      = 1'b0;
    o_instr_count = '0;
    if (!i_reset) begin
      o_pc_addr     = pc;
      o_operand     = ir[NB_OPERAND-1:0];
      o_instr_count = count;
      case (state)
        IDLE: begin
          if (i_start) next_state = FETCH;
        end
        FETCH: begin
          o_busy     = 1'b1;
          o_rd_prog  = 1'b1;
          next_state = DECODE;
        end
        DECODE: begin
          o_busy = 1'b1;
          if (dec_opcode == OP_LD || dec_opcode == OP_ADD || dec_opcode == OP_SUB) begin
            o_rd_data   = 1'b1;
            o_data_addr = i_instruction[NB_ADDR-1:0];
          end
          next_state = (dec_opcode == OP_HLT) ? HALT : EXEC;
        end
        EXEC: begin
          o_busy     = 1'b1;
          next_state = FETCH;
          case (ex_opcode)
            OP_STO: begin
              o_wr_data   = 1'b1;
              o_data_addr = ir[NB_ADDR-1:0];
            end
            OP_LD: begin
              o_sel_a   = 2'b00;
              o_enb_acc = 1'b1;
            end
            OP_LDI: begin
              o_sel_a   = 2'b01;
              o_enb_acc = 1'b1;
            end
            OP_ADD: begin
              o_sel_a   = 2'b10;
              o_enb_acc = 1'b1;
            end
            OP_ADDI: begin
              o_sel_a   = 2'b10;
              o_sel_b   = 1'b1;
              o_enb_acc = 1'b1;
            end
            OP_SUB: begin
              o_sel_a     = 2'b10;
              o_operation = 1'b1;
              o_enb_acc   = 1'b1;
            end
            OP_SUBI: begin
              o_sel_a     = 2'b10;
              o_sel_b     = 1'b1;
              o_operation = 1'b1;
              o_enb_acc   = 1'b1;
            end
            default: ;
          endcase
        end
        HALT: begin
          o_halted = 1'b1;
          if (i_start) next_state = FETCH;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// Testbench for bip_control_unit: a program memory answers the fetch strobe,
// and an instruction-level model predicts the outputs of every cycle.
module tb_bip_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc_addr;
  logic        rd_prog;
  logic [10:0] data_addr;
  logic        rd_data;
  logic        wr_data;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        enb_acc;
  logic        operation;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] mem [0:2047];
  logic [58:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  logic [10:0] m_pc;
  logic [15:0] m_cnt;
  logic [10:0] m_opnd;

  bip_control_unit dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_instruction (instr),
    .o_pc_addr     (pc_addr),
    .o_rd_prog     (rd_prog),
    .o_data_addr   (data_addr),
    .o_rd_data     (rd_data),
    .o_wr_data     (wr_data),
    .o_operand     (operand),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_enb_acc     (enb_acc),
    .o_operation   (operation),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Synchronous program memory: the word addressed during FETCH is presented in DECODE.
  always @(posedge clock) begin
    if (rd_prog) instr <= mem[pc_addr];
  end

  assign obs = {pc_addr, rd_prog, data_addr, rd_data, wr_data, operand,
                sel_a, sel_b, enb_acc, operation, busy, halted, instr_count};

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [58:0] mk(
    input logic [10:0] pa, input logic rp, input logic [10:0] da,
    input logic rd, input logic wr, input logic [10:0] opd,
    input logic [1:0] sa, input logic sb, input logic en, input logic op,
    input logic bz, input logic hl, input logic [15:0] cnt);
    return {pa, rp, da, rd, wr, opd, sa, sb, en, op, bz, hl, cnt};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [58:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    start = 1'b0;
    tick();
    check({tag, "_rst_held"}, '0);
    reset = 1'b0;
    #1;
    check({tag, "_idle"}, '0);
    m_pc   = '0;
    m_cnt  = '0;
    m_opnd = '0;
  endtask

  // Start from IDLE/HALT and execute up to max_instr instructions against the model.
  task automatic run(input string tag, input int max_instr);
    logic [15:0] w;
    logic [4:0]  opc;
    logic        rd, wr, sb, en, opn;
    logic [1:0]  sa;
    logic [10:0] da;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc  = '0;
    m_cnt = '0;
    for (int k = 0; k < max_instr; k++) begin
      w   = mem[m_pc];
      opc = w[15:11];
      check({tag, "_fetch"}, mk(m_pc, 1'b1, 11'd0, 1'b0, 1'b0, m_opnd, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_cnt));
      start = 1'($urandom);
      tick();
      rd = (opc == 5'd2 || opc == 5'd4 || opc == 5'd6);
      check({tag, "_decode"}, mk(m_pc, 1'b0, rd ? w[10:0] : 11'd0, rd, 1'b0, m_opnd, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_cnt));
      start = 1'($urandom);
      tick();
      m_opnd = w[10:0];
      if (opc == 5'd0) begin
        start = 1'b0;
        for (int h = 0; h < 3; h++) begin
          check({tag, "_halt"}, mk(m_pc, 1'b0, 11'd0, 1'b0, 1'b0, m_opnd, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_cnt));
          tick();
        end
        return;
      end
      wr = 1'b0; da = '0; sa = 2'd0; sb = 1'b0; en = 1'b0; opn = 1'b0;
      if (opc == 5'd1) begin
        wr = 1'b1;
        da = m_opnd;
      end else if (opc == 5'd2) begin
        en = 1'b1;
      end else if (opc == 5'd3) begin
        sa = 2'd1;
        en = 1'b1;
      end else if (opc >= 5'd4 && opc <= 5'd7) begin
        sa  = 2'd2;
        en  = 1'b1;
        sb  = opc[0];
        opn = opc[1];
      end
      check({tag, "_exec"}, mk(m_pc, 1'b0, da, 1'b0, wr, m_opnd, sa, sb, en, opn, 1'b1, 1'b0, m_cnt));
      start = 1'($urandom);
      tick();
      m_pc = m_pc + 11'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
    tick();
    do_reset("init");

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("rst_vs_start", '0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("rst_vs_start_idle", '0);

    // LDI 5 ; HLT
    mem[0] = 16'h1805;
    mem[1] = 16'h0000;
    run("ldi", 10);
    check("ldi_final", mk(11'd1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1));

    // LD 0x10 ; ADD 0x11 ; STO 0x12 ; HLT
    do_reset("prog2");
    mem[0] = 16'h1010;
    mem[1] = 16'h2011;
    mem[2] = 16'h0812;
    mem[3] = 16'h0000;
    run("ldaddsto", 10);
    check("ldaddsto_final", mk(11'd3, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3));

    // ADDI 0x7FF ; SUBI 3 ; HLT, then restart straight from HALT
    do_reset("prog3");
    mem[0] = 16'h2FFF;
    mem[1] = 16'h3803;
    mem[2] = 16'h0000;
    run("addisubi", 10);
    run("restart", 10);

    // Reset caught in the EXEC cycle of a STO.
    do_reset("prog4");
    mem[0] = 16'h0812;
    mem[1] = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b1;
    check("sto_fetch", mk(11'd0, 1'b1, 11'd0, 1'b0, 1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    tick();
    start = 1'b0;
    check("sto_decode", mk(11'd0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    tick();
    check("sto_exec", mk(11'd0, 1'b0, 11'h012, 1'b0, 1'b1, 11'h012, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    reset = 1'b1;
    #1;
    check("sto_exec_rst", '0);
    tick();
    reset = 1'b0;
    #1;
    check("sto_after_rst", '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sto_stays_idle", '0);
    end
    m_pc = '0; m_cnt = '0; m_opnd = '0;

    // Random programs terminated by HLT.
    for (int p = 0; p < 15; p++) begin
      int len;
      logic [4:0] opc;
      do_reset("rnd");
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) opc = 5'($urandom_range(8, 31));
        else                           opc = 5'($urandom_range(1, 7));
        mem[i] = {opc, 11'($urandom)};
      end
      mem[len] = 16'h0000;
      run("rnd", len + 2);
    end

    // A memory full of NOP encodings: PC must wrap from 0x7FF back to 0.
    for (int i = 0; i < 2048; i++) mem[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
    do_reset("nop");
    run("nopwrap", 2050);
    check("nopwrap_pc", mk(11'd2, 1'b1, 11'd0, 1'b0, 1'b0, m_opnd, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2050));
    do_reset("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
BIP_CONTROL_UNIT -- requirements
Module: bip_control_unit

Interface
REQ-001 Parameters SHALL be: NB_INSTRUCTION, 16, instruction width; NB_ADDR, 11, program/data address width; NB_OPCODE, 5, opcode width; NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand width; NB_SELECTOR_A, 2, accumulator-mux select width.
REQ-002 Clock and reset SHALL be i_clock and i_reset: synchronous, active-high reset; clock i_clock.
REQ-003 Ports SHALL be:
 i_clock  in  1  clock
 i_reset  in  1  sync active-high reset
 i_start  in  1  start pulse, sampled in IDLE/HALT only
 i_instruction  in  NB_INSTRUCTION  program-memory read data, valid one cycle after o_rd_prog
 o_pc_addr  out  NB_ADDR  program counter, drives program-memory address
 o_rd_prog  out  1  program-memory read strobe
 o_data_addr  out  NB_ADDR  data-memory address
 o_rd_data  out  1  data-memory read strobe
 o_wr_data  out  1  data-memory write strobe
 o_operand  out  NB_OPERAND  latched operand field to datapath
 o_sel_a  out  NB_SELECTOR_A  accumulator input select
 o_sel_b  out  1  adder B select
 o_enb_acc  out  1  accumulator load enable
 o_operation  out  1  0 add, 1 sub
 o_busy  out  1  high in FETCH/DECODE/EXEC
 o_halted  out  1  high in HALT
 o_instr_count  out  16  retired-instruction counter

Function
REQ-004 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, HALT; every instruction except HLT SHALL take exactly 3 cycles (FETCH, DECODE, EXEC).
REQ-005 IDLE: i_start=1 -> PC<=0, o_instr_count<=0, next FETCH; else stay.
REQ-006 FETCH: o_rd_prog=1, o_pc_addr=PC; next DECODE.
REQ-007 DECODE: IR<=i_instruction; opcode=IR[15:11], operand=IR[10:0]; HLT(00000) -> HALT, PC unchanged, count unchanged; else next EXEC.
REQ-008 DECODE for LD(00010), ADD(00100), SUB(00110) SHALL assert o_rd_data=1 with o_data_addr=i_instruction[NB_ADDR-1:0] so data is valid in EXEC.
REQ-009 EXEC decode table, single-cycle strobes:
 STO 00001: o_wr_data=1, o_data_addr=operand
 LD 00010: sel_a=00, enb_acc=1
 LDI 00011: sel_a=01, enb_acc=1
 ADD 00100: sel_a=10, sel_b=0, op=0, enb_acc=1
 ADDI 00101: sel_a=10, sel_b=1, op=0, enb_acc=1
 SUB 00110: sel_a=10, sel_b=0, op=1, enb_acc=1
 SUBI 00111: sel_a=10, sel_b=1, op=1, enb_acc=1
 other opcodes: NOP, no strobes.
REQ-010 EXEC SHALL increment PC by 1 modulo 2^NB_ADDR (0x7FF -> 0x000), increment o_instr_count (saturating at 0xFFFF), next FETCH.
REQ-011 Outside EXEC/DECODE as listed, o_enb_acc, o_wr_data, o_rd_data, o_sel_b, o_operation SHALL be 0 and o_sel_a 00; o_rd_prog SHALL be 0 outside FETCH.
REQ-012 o_operand SHALL hold IR operand from DECODE until next DECODE; o_data_addr SHALL be 0 when no data strobe is active.
REQ-013 HALT: o_halted=1, all strobes 0, PC and count held; i_start=1 -> PC<=0, count<=0, next FETCH.
REQ-014 i_start in FETCH/DECODE/EXEC SHALL be ignored.
REQ-015 o_rd_data and o_wr_data SHALL never be asserted in the same cycle.

Reset
REQ-016 i_reset=1 at any clock edge, including mid-instruction, SHALL force IDLE, PC=0, IR=0, o_instr_count=0, all outputs 0; an in-flight instruction SHALL retire no strobes afterward.
REQ-017 Reset SHALL take priority over i_start in the same cycle.

Verification
REQ-018 Reset then i_start pulse; program LDI 5, HLT -> cycle 3 after start o_sel_a=01, o_enb_acc=1, o_operand=5; halt after 5 cycles, o_instr_count=1, o_pc_addr=1.
REQ-019 Program LD 0x10, ADD 0x11, STO 0x12, HLT -> o_rd_data at DECODE with o_data_addr 0x10/0x11, ADD EXEC sel_a=10 sel_b=0 op=0, o_wr_data one cycle with o_data_addr=0x12, count=3.
REQ-020 ADDI 0x7FF then SUBI 3 -> o_operand=0x7FF with sel_b=1 op=0, then o_operand=3 with op=1; no o_rd_data asserted.
REQ-021 PC preloaded path: 2048 NOPs (opcode 11111) -> o_pc_addr wraps 0x7FF -> 0x000, no strobes asserted.
REQ-022 Assert i_reset during EXEC of STO -> no o_wr_data that cycle or after, IDLE next cycle, all outputs 0; i_start mid-FETCH has no effect.
REQ-023 In HALT, i_start pulse -> FETCH next cycle with o_pc_addr=0, o_halted=0, o_instr_count=0.
